psram_req_queue: RTL and testbench

Request buffer and sequencer placed directly upstream of the `psram` controller. Accepts read/write requests from one client over a valid/ready handshake and buffers them in a small FIFO. Issues them to the controller one at a time as single-cycle `write_en`/`read_en` pulses, paces writes with a fixed holdoff, and returns read data as a one-cycle response pulse. Core logic never has to track controller timing.

---
 rtl/psram_pkg.sv | 20 ++
 rtl/psram_req_fifo.sv | 50 +++++
 rtl/psram_req_queue.sv | 128 ++++++++++++
 tb/tb_psram_req_queue.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types for the PSRAM request path: sequencer states and the queued request word.
package psram_pkg;

  localparam int unsigned PSRAM_ADDR_W = 22;
  localparam int unsigned PSRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT
  } psram_state_t;

  typedef struct packed {
    logic                    write;
    logic                    bank;
    logic [PSRAM_ADDR_W-1:0] addr;
    logic [PSRAM_DATA_W-1:0] data;
  } psram_req_t;

endpackage

// File: rtl/psram_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to separate full from empty.
module psram_req_fifo
  import psram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  psram_req_t               push_data,
  input  logic                     pop,
  output psram_req_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  psram_req_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only visible once wr_ptr has moved past it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/psram_req_queue.sv
// Buffers client requests and issues them to the psram controller one at a time,
// pacing writes with a fixed holdoff and turning each read into exactly one response.
module psram_req_queue
  import psram_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned WRITE_HOLDOFF = 8,
  parameter int unsigned READ_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_bank,
  input  logic [PSRAM_ADDR_W-1:0] req_addr,
  input  logic [PSRAM_DATA_W-1:0] req_data,
  output logic                    rsp_valid,
  output logic [PSRAM_DATA_W-1:0] rsp_data,
  output logic                    psram_bank_sel,
  output logic [PSRAM_ADDR_W-1:0] psram_addr,
  output logic [PSRAM_DATA_W-1:0] psram_data_in,
  output logic                    psram_write_en,
  output logic                    psram_read_en,
  input  logic                    psram_read_avail,
  input  logic [PSRAM_DATA_W-1:0] psram_data_out,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned CNT_MAX = (WRITE_HOLDOFF > READ_TIMEOUT) ? WRITE_HOLDOFF : READ_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  psram_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             avail_q;
  logic             read_rise;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count;
  psram_req_t       push_req;
  psram_req_t       head;

  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign push_req  = '{write: req_write, bank: req_bank, addr: req_addr, data: req_data};
  assign busy      = (state != IDLE) || (count != '0);
  // A level left high by the previous read must not complete the current one.
  assign read_rise = psram_read_avail && !avail_q;

  psram_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(push_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      avail_q        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      psram_bank_sel <= 1'b0;
      psram_addr     <= '0;
      psram_data_in  <= '0;
      psram_write_en <= 1'b0;
      psram_read_en  <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      avail_q        <= psram_read_avail;
      rsp_valid      <= 1'b0;
      psram_write_en <= 1'b0;
      psram_read_en  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            psram_bank_sel <= head.bank;
            psram_addr     <= head.addr;
            psram_data_in  <= head.data;
            if (head.write) begin
              psram_write_en <= 1'b1;
              cnt            <= CNT_W'(WRITE_HOLDOFF);
              state          <= WR_WAIT;
            end else begin
              psram_read_en <= 1'b1;
              cnt           <= CNT_W'(READ_TIMEOUT);
              state         <= RD_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (cnt == CNT_ONE) state <= IDLE;
          else                cnt   <= cnt - CNT_ONE;
        end
        RD_WAIT: begin
          if (read_rise) begin
            rsp_data  <= psram_data_out;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else if (cnt == CNT_ONE) begin
            timeout_err <= 1'b1;
            rsp_data    <= '0;
            rsp_valid   <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_req_queue.sv
// Scoreboard bench for psram_req_queue with a simple behavioural psram read model.
module tb_psram_req_queue;

  localparam int H = 8;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_bank;
  logic [21:0] req_addr;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        psram_bank_sel;
  logic [21:0] psram_addr;
  logic [15:0] psram_data_in;
  logic        psram_write_en;
  logic        psram_read_en;
  logic        psram_read_avail;
  logic [15:0] psram_data_out;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    bit          wr;
    bit          bank;
    logic [21:0] addr;
    logic [15:0] data;
    int          gap;
  } iss_t;

  typedef struct {
    logic [15:0] data;
    int          lat;
  } rsp_t;

  iss_t        exp_issue[$];
  rsp_t        exp_rsp[$];
  logic [15:0] model_data[$];
  bit          model_silent = 1'b0;
  int          model_delay  = 6;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;

  psram_req_queue #(
    .DEPTH        (4),
    .WRITE_HOLDOFF(H),
    .READ_TIMEOUT (T)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_bank        (req_bank),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .psram_bank_sel  (psram_bank_sel),
    .psram_addr      (psram_addr),
    .psram_data_in   (psram_data_in),
    .psram_write_en  (psram_write_en),
    .psram_read_en   (psram_read_en),
    .psram_read_avail(psram_read_avail),
    .psram_data_out  (psram_data_out),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Read model: read_en drops read_avail, which rises again model_delay cycles later.
  initial begin
    int pend;
    pend = 0;
    psram_read_avail = 1'b0;
    psram_data_out   = '0;
    forever begin
      @(negedge clk);
      if (psram_read_en && !model_silent) begin
        psram_read_avail = 1'b0;
        pend = model_delay;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          psram_data_out   = (model_data.size() != 0) ? model_data.pop_front() : 16'hFFFF;
          psram_read_avail = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues or responds.
  initial begin
    iss_t        e;
    rsp_t        r;
    bit          prev_en;
    bit          have_last;
    bit          en;
    logic        last_bank;
    logic [21:0] last_addr;
    logic [15:0] last_data;
    int          last_en_cyc;
    int          last_rd_cyc;
    prev_en = 0; have_last = 0; last_en_cyc = 0; last_rd_cyc = 0;
    last_bank = 0; last_addr = '0; last_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        have_last = 0;
        prev_en   = 0;
        continue;
      end
      en = psram_write_en || psram_read_en;
      check("en_overlap", 32'(psram_write_en && psram_read_en), 32'(0));
      if (en && prev_en) check("en_pulse_width", 32'(1), 32'(0));
      if (en) begin
        if (exp_issue.size() == 0) begin
          check("unexpected_issue", 32'(en), 32'(0));
        end else begin
          e = exp_issue.pop_front();
          check("issue_kind", 32'(psram_write_en), 32'(e.wr));
          check("issue_bank", 32'(psram_bank_sel), 32'(e.bank));
          check("issue_addr", 32'(psram_addr), 32'(e.addr));
          if (e.wr) check("issue_data", 32'(psram_data_in), 32'(e.data));
          if (e.gap != 0) check("issue_gap", 32'(cyc - last_en_cyc), 32'(e.gap));
        end
        last_en_cyc = cyc;
        if (psram_read_en) last_rd_cyc = cyc;
        have_last = 1;
        last_bank = psram_bank_sel;
        last_addr = psram_addr;
        last_data = psram_data_in;
      end else if (have_last) begin
        check("issue_hold", {psram_bank_sel, psram_addr, psram_data_in[8:0]},
              {last_bank, last_addr, last_data[8:0]});
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'(0));
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(r.data));
          check("rsp_latency", 32'(cyc - last_rd_cyc), 32'(r.lat));
        end
      end
      prev_en = en;
    end
  end

  task automatic send(input bit wr, input bit bank, input logic [21:0] addr,
                      input logic [15:0] data, input int gap,
                      input logic [15:0] rdata, input int lat, input bit feed_model);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_bank  = bank;
    req_addr  = addr;
    req_data  = data;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("send_ready_timeout", 32'(req_ready), 32'(1));
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      exp_issue.push_back('{wr, bank, addr, data, gap});
      if (!wr) begin
        exp_rsp.push_back('{rdata, lat});
        if (feed_model) model_data.push_back(rdata);
      end
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_issue.size() != 0 || exp_rsp.size() != 0) && n < 400);
    check("drain_idle", 32'(busy || exp_issue.size() != 0 || exp_rsp.size() != 0), 32'(0));
  endtask

  initial begin
    int hold_bad;
    int seen;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_bank  = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_psram_outs",
          32'({psram_bank_sel, psram_addr, psram_data_in, psram_write_en, psram_read_en} != '0), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_timeout_err", 32'(timeout_err), 32'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write: enable one cycle after acceptance, busy clears H+1 after acceptance.
    send(1, 0, 22'h2F0B00, 16'hCCBB, 0, '0, 0, 0);
    hold_bad = 0;
    for (int k = 0; k <= H + 1; k++) begin
      @(negedge clk);
      if (k == 0) check("wr_en_before", 32'(psram_write_en), 32'(0));
      if (k == 1) check("wr_en_pulse", 32'(psram_write_en), 32'(1));
      if (k == 2) check("wr_en_after", 32'(psram_write_en), 32'(0));
      if (k <= H && !busy) hold_bad++;
      if (k == H + 1) check("wr_busy_fall", 32'(busy), 32'(0));
    end
    check("wr_busy_hold", 32'(hold_bad), 32'(0));

    // Single read, read_avail 6 cycles after read_en.
    model_delay = 6;
    send(0, 1, 22'h2F0B00, 16'h0000, 0, 16'hABCD, 7, 1);
    drain();

    // Fill: five back-to-back writes with the first one outstanding.
    send(1, 0, 22'h000100, 16'h1001, 0, '0, 0, 0);
    send(1, 1, 22'h000200, 16'h2002, H + 1, '0, 0, 0);
    send(1, 0, 22'h000300, 16'h3003, H + 1, '0, 0, 0);
    send(1, 1, 22'h000400, 16'h4004, H + 1, '0, 0, 0);
    check("fill_ready_at_3", 32'(req_ready), 32'(1));
    send(1, 0, 22'h3FFFFF, 16'h5005, H + 1, '0, 0, 0);
    @(negedge clk);
    check("fill_ready_full", 32'(req_ready), 32'(0));
    drain();

    // Stale read_avail: level still high, model stays silent -> timeout.
    check("timeout_err_pre", 32'(timeout_err), 32'(0));
    check("stale_avail_level", 32'(psram_read_avail), 32'(1));
    model_silent = 1'b1;
    send(0, 0, 22'h155555, 16'h0000, 0, 16'h0000, T, 0);
    drain();
    check("timeout_err_set", 32'(timeout_err), 32'(1));

    // Mixed W, R, W, R.
    model_silent = 1'b0;
    model_delay  = 3;
    send(1, 0, 22'h000010, 16'hA5A5, 0, '0, 0, 0);
    send(0, 1, 22'h000020, 16'h0000, H + 1, 16'h1111, 4, 1);
    send(1, 1, 22'h000030, 16'h5A5A, 0, '0, 0, 0);
    send(0, 0, 22'h000040, 16'h0000, H + 1, 16'h2222, 4, 1);
    drain();
    check("timeout_err_sticky", 32'(timeout_err), 32'(1));

    // Reset while in RD_WAIT with two writes queued, plus a push during reset.
    model_silent = 1'b1;
    send(0, 1, 22'h0ABCDE, 16'h0000, 0, 16'h0000, 0, 0);
    send(1, 0, 22'h000050, 16'h7777, 0, '0, 0, 0);
    send(1, 1, 22'h000060, 16'h8888, 0, '0, 0, 0);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'(1));
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 22'h000070;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_ready", 32'(req_ready), 32'(1));
    check("midrst_rsp", 32'(rsp_valid), 32'(0));
    check("midrst_addr", 32'(psram_addr), 32'(0));
    check("midrst_timeout_err", 32'(timeout_err), 32'(0));
    exp_issue.delete();
    exp_rsp.delete();
    req_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    psram_read_avail = 1'b0;
    @(negedge clk);
    psram_data_out   = 16'hDEAD;
    psram_read_avail = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || psram_read_en || psram_write_en || busy) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
